// File: rtl/nn_output_collector.sv
// nn_output_collector: gathers one activation per output neuron, then
// presents the vector; argmax class/max enabled by NN_COLLECT_ARGMAX_EN.
module nn_output_collector #(
   parameter int NumOutputLayer = 2,
   parameter int IdxW = (NumOutputLayer > 1) ? $clog2(NumOutputLayer) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [32*NumOutputLayer-1:0] actv_i,
   input  logic [NumOutputLayer-1:0]    req_i,
   output logic [NumOutputLayer-1:0]    ack_o,
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic [32*NumOutputLayer-1:0] result_data_o,
   output logic [IdxW-1:0]              class_o,
   output logic [31:0]                  max_o,
   output logic                         busy_o
);

   typedef enum logic [1:0] {
      COLLECT,
      SCAN,
      PRESENT
   } state_t;

   state_t state;

   logic [31:0]               data     [NumOutputLayer];
   logic [31:0]               data_nxt [NumOutputLayer];
   logic [NumOutputLayer-1:0] full;
   logic [NumOutputLayer-1:0] cap;
   logic                      all_full;
   logic                      hs;

   // capture only empty slots while collecting; compute post-capture data
   always_comb begin
      cap = '0;
      if (state == COLLECT) cap = req_i & ~full;
      for (int k = 0; k < NumOutputLayer; k++) begin
         data_nxt[k] = cap[k] ? actv_i[32*k +: 32] : data[k];
      end
   end

   assign all_full = &(full | cap);
   assign hs       = result_valid_o & result_ready_i;

   for (genvar k = 0; k < NumOutputLayer; k++) begin : g_out
      assign result_data_o[32*k +: 32] = data[k];
   end

   // slot registers; reset discards anything captured so far
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < NumOutputLayer; k++) data[k] <= '0;
      end else begin
         for (int k = 0; k < NumOutputLayer; k++) data[k] <= data_nxt[k];
      end
   end

   // full mask: set on capture, cleared by the result handshake
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full <= '0;
      end else if (state == PRESENT && hs) begin
         full <= '0;
      end else begin
         full <= full | cap;
      end
   end

`ifdef NN_COLLECT_ARGMAX_EN
   logic [IdxW-1:0] scan_idx;
   logic [IdxW-1:0] best_idx;
   logic [IdxW-1:0] cur_idx;
   logic [IdxW-1:0] nxt_idx;
   logic [31:0]     best_val;
   logic [31:0]     cur_val;
   logic [31:0]     cand_val;
   logic [31:0]     nxt_val;
   logic            first_step;

   // one signed compare per scan step; first step seeds best from slot 0
   always_comb begin
      first_step = (scan_idx == IdxW'(1));
      cand_val   = data[scan_idx];
      cur_val    = first_step ? data[0] : best_val;
      cur_idx    = first_step ? '0 : best_idx;
      nxt_idx    = cur_idx;
      nxt_val    = cur_val;
      if ($signed(cand_val) > $signed(cur_val)) begin
         nxt_idx = scan_idx;
         nxt_val = cand_val;
      end
   end
`else
   assign class_o = '0;
   assign max_o   = '0;
`endif

   // control FSM with registered ack/valid/busy and result registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state          <= COLLECT;
         ack_o          <= '0;
         result_valid_o <= 1'b0;
         busy_o         <= 1'b0;
`ifdef NN_COLLECT_ARGMAX_EN
         scan_idx       <= '0;
         best_idx       <= '0;
         best_val       <= '0;
         class_o        <= '0;
         max_o          <= '0;
`endif
      end else begin
         ack_o <= cap;
         unique case (state)
            COLLECT: begin
               if (all_full) begin
                  busy_o <= 1'b1;
`ifdef NN_COLLECT_ARGMAX_EN
                  if (NumOutputLayer > 1) begin
                     state    <= SCAN;
                     scan_idx <= IdxW'(1);
                  end else begin
                     state          <= PRESENT;
                     result_valid_o <= 1'b1;
                     class_o        <= '0;
                     max_o          <= data_nxt[0];
                  end
`else
                  state          <= PRESENT;
                  result_valid_o <= 1'b1;
`endif
               end
            end
            SCAN: begin
`ifdef NN_COLLECT_ARGMAX_EN
               best_idx <= nxt_idx;
               best_val <= nxt_val;
               scan_idx <= scan_idx + IdxW'(1);
               if (scan_idx == IdxW'(NumOutputLayer - 1)) begin
                  state          <= PRESENT;
                  result_valid_o <= 1'b1;
                  class_o        <= nxt_idx;
                  max_o          <= nxt_val;
               end
`else
               state  <= COLLECT;
               busy_o <= 1'b0;
`endif
            end
            PRESENT: begin
               if (hs) begin
                  state          <= COLLECT;
                  result_valid_o <= 1'b0;
                  busy_o         <= 1'b0;
               end
            end
            default: begin
               state          <= COLLECT;
               result_valid_o <= 1'b0;
               busy_o         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_output_collector.sv
// tb_nn_output_collector: directed scoreboard bench, N=3; expectations
// follow NN_COLLECT_ARGMAX_EN when defined for the build.
module tb_nn_output_collector;

   localparam int N = 3;

`ifdef NN_COLLECT_ARGMAX_EN
   localparam int LAT = N;
   localparam bit ARGMAX = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit ARGMAX = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_i;
   logic [95:0]   actv_i;
   logic [2:0]    req_i;
   logic [2:0]    ack_o;
   logic          result_valid_o;
   logic          result_ready_i;
   logic [95:0]   result_data_o;
   logic [1:0]    class_o;
   logic [31:0]   max_o;
   logic          busy_o;

   typedef struct {
      logic [95:0] data;
      logic [1:0]  cls;
      logic [31:0] mx;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   nn_output_collector #(.NumOutputLayer(N)) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .actv_i         (actv_i),
      .req_i          (req_i),
      .ack_o          (ack_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_data_o  (result_data_o),
      .class_o        (class_o),
      .max_o          (max_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act,
                      input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [1:0] cls,
                       input logic [31:0] mx);
      exp_t e;
      e.data = {d2, d1, d0};
      e.cls  = ARGMAX ? cls : 2'd0;
      e.mx   = ARGMAX ? mx : 32'd0;
      exp_q.push_back(e);
   endtask

   // from cycle T+1: valid must stay low until T+LAT, high there
   task automatic check_latency();
      for (int i = 1; i <= LAT; i++) begin
         chk("valid_rise", result_valid_o, (i == LAT));
         chk("busy", busy_o, 1'b1);
         if (i < LAT) tick();
      end
   endtask

   // monitor: compare every accepted result against the scoreboard
   always @(negedge clk) begin
      if (result_valid_o && result_ready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %h expected none",
                     result_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_data", result_data_o, e.data);
            chk("res_class", class_o, e.cls);
            chk("res_max", max_o, e.mx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i        = 1'b1;
      req_i          = '0;
      actv_i         = '0;
      result_ready_i = 1'b1;
      tick();
      tick();
      chk("rst_ack", ack_o, 3'b000);
      chk("rst_valid", result_valid_o, 1'b0);
      chk("rst_data", result_data_o, 96'd0);
      chk("rst_class", class_o, 2'd0);
      chk("rst_max", max_o, 32'd0);
      chk("rst_busy", busy_o, 1'b0);
      reset_i = 1'b0;
      tick();

      // staggered requests 5, -2, 9
      req_i = 3'b001; actv_i[31:0] = 32'd5;
      tick();
      chk("t1_ack0", ack_o, 3'b001);
      req_i = 3'b010; actv_i[63:32] = 32'hFFFF_FFFE;
      tick();
      chk("t1_ack1", ack_o, 3'b010);
      req_i = 3'b100; actv_i[95:64] = 32'd9;
      tick();
      chk("t1_ack2", ack_o, 3'b100);
      req_i = 3'b000;
      push(32'd5, 32'hFFFF_FFFE, 32'd9, 2'd2, 32'd9);
      check_latency();
      tick();
      chk("t1_valid_drop", result_valid_o, 1'b0);
      chk("t1_busy_drop", busy_o, 1'b0);

      // simultaneous requests, signed max with tie
      req_i  = 3'b111;
      actv_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      tick();
      chk("t2_ack", ack_o, 3'b111);
      req_i = 3'b000;
      push(32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1,
           32'hFFFF_FFFF);
      check_latency();
      tick();
      chk("t2_valid_drop", result_valid_o, 1'b0);

      // backpressure: hold ready low while req[0] re-raised
      result_ready_i = 1'b0;
      req_i  = 3'b111;
      actv_i = {32'd30, 32'd20, 32'd10};
      tick();
      chk("t3_ack", ack_o, 3'b111);
      req_i = 3'b000;
      push(32'd10, 32'd20, 32'd30, 2'd2, 32'd30);
      check_latency();
      req_i = 3'b001; actv_i[31:0] = 32'd77;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold_valid", result_valid_o, 1'b1);
         chk("t3_hold_ack", ack_o, 3'b000);
         chk("t3_hold_data", result_data_o, {32'd30, 32'd20, 32'd10});
         chk("t3_hold_class", class_o, ARGMAX ? 2'd2 : 2'd0);
         chk("t3_hold_max", max_o, ARGMAX ? 32'd30 : 32'd0);
      end
      result_ready_i = 1'b1;
      tick();
      chk("t3_post_valid", result_valid_o, 1'b0);
      chk("t3_post_ack", ack_o, 3'b000);
      tick();
      chk("t3_recapture_ack", ack_o, 3'b001);

      // req[1] held after its slot is full: single ack, data kept
      req_i = 3'b010; actv_i[63:32] = 32'd88;
      tick();
      chk("t4_ack1", ack_o, 3'b010);
      actv_i[63:32] = 32'h0000_DEAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_no_ack", ack_o, 3'b000);
      end
      req_i = 3'b100; actv_i[95:64] = 32'd99;
      tick();
      chk("t4_ack2", ack_o, 3'b100);
      req_i = 3'b000;
      push(32'd77, 32'd88, 32'd99, 2'd2, 32'd99);
      check_latency();
      tick();
      chk("t4_valid_drop", result_valid_o, 1'b0);

      // reset mid-operation with requests pending
      result_ready_i = 1'b0;
      req_i  = 3'b111;
      actv_i = {32'd6, 32'd5, 32'd4};
      tick();
      chk("t5_ack", ack_o, 3'b111);
      reset_i = 1'b1;
      tick();
      chk("t5_rst_ack", ack_o, 3'b000);
      chk("t5_rst_valid", result_valid_o, 1'b0);
      chk("t5_rst_data", result_data_o, 96'd0);
      chk("t5_rst_class", class_o, 2'd0);
      chk("t5_rst_max", max_o, 32'd0);
      chk("t5_rst_busy", busy_o, 1'b0);
      reset_i        = 1'b0;
      result_ready_i = 1'b1;
      actv_i         = {32'd3, 32'd2, 32'd1};
      tick();
      chk("t5_re_ack", ack_o, 3'b111);
      req_i = 3'b000;
      push(32'd1, 32'd2, 32'd3, 2'd2, 32'd3);
      check_latency();
      tick();
      chk("t5_valid_drop", result_valid_o, 1'b0);

      tick();
      chk("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nn_output_collector.md
# nn_output_collector

Downstream stage of the feed-forward network. Sits on the output-layer neurons' `actv_o`/`req_o`/`ack_i` buses. Captures one 32-bit activation per output neuron through the per-neuron req/ack handshake and, once every output has arrived, presents the full output vector. Optionally it also presents the winning class index (argmax) on a single valid/ready result port.

## Interface
Parameters:
- `NumOutputLayer`, default 2: number of output neurons; legal range 1..16.
- `IdxW`, default `(NumOutputLayer > 1) ? $clog2(NumOutputLayer) : 1`: width of the class index.

Ports:
- `clk_i`, input, 1: single clock.
- `reset_i`, input, 1: reset, synchronous, active-high.
- `actv_i`, input, 32*NumOutputLayer: output-neuron activations; slot k is `[32k+:32]`, signed two's complement.
- `req_i`, input, NumOutputLayer: per-neuron request; a level, held by the neuron until acked.
- `ack_o`, output, NumOutputLayer: per-neuron acknowledge; registered, one-cycle pulse.
- `result_valid_o`, output, 1: result vector/class valid.
- `result_ready_i`, input, 1: result consumer ready.
- `result_data_o`, output, 32*NumOutputLayer: captured activation vector.
- `class_o`, output, IdxW: index of the maximum activation.
- `max_o`, output, 32: value of the maximum activation.
- `busy_o`, output, 1: high whenever the state is not COLLECT.

## Operation
- Internal state: slot registers `data[k]`, full mask `full[k]`, FSM {COLLECT, SCAN, PRESENT}, scan index, running best index and value.
- COLLECT capture rule:
  - For each k with `req_i[k]=1` and `full[k]=0`: latch `actv_i[k]` into `data[k]` and set `full[k]`.
  - `ack_o[k]` pulses high the following cycle.
  - Any number of slots may capture in the same cycle.
- A request with `full[k]=1` is ignored: no ack, data not overwritten. The neuron keeps req high and is served after the next release.
- When all `full` bits are set (including via captures in the current cycle), the FSM goes to SCAN, or straight to PRESENT if `NumOutputLayer==1` or the macro is absent.
- SCAN:
  - Best starts as index 0 / `data[0]`.
  - Each cycle compares `data[i]` for i = 1..N-1 using a signed compare; strictly greater replaces best. Ties keep the lower index.
  - After i = N-1, go to PRESENT.
- PRESENT:
  - `result_valid_o=1` with `result_data_o`, `class_o`, `max_o` held stable.
  - Requests are not acked in this state.
  - On `result_valid_o & result_ready_i`: clear all `full` bits and return to COLLECT.
- Reset values: `ack_o=0`, `result_valid_o=0`, `result_data_o=0`, `class_o=0`, `max_o=0`, `busy_o=0`, all `full=0`, state COLLECT.
- Reset mid-operation: all captured data is discarded and no ack is issued for pending requests. Neurons re-present after reset.

## Timing
- Capture cycle C yields an `ack_o[k]` pulse at C+1 only.
- Let T be the cycle in which the last slot captures:
  - With the macro: SCAN occupies T+1..T+N-1 and `result_valid_o` rises at T+N.
  - Without the macro, or N=1: `result_valid_o` rises at T+1.
- The handshake completes at cycle P. COLLECT resumes at P+1, and a request held high is captured at P+1 (acked at P+2).
- Back-to-back throughput without the macro: one vector per 2 cycles minimum.
- `result_valid_o` never drops without a handshake; outputs are stable while valid and not ready.

## Configuration
- `NN_COLLECT_ARGMAX_EN` defined:
  - SCAN state, comparator and best registers are compiled in.
  - `class_o`/`max_o` carry the argmax per the rules above.
- Not defined:
  - SCAN is removed; COLLECT goes directly to PRESENT.
  - `class_o` is tied to 0 and `max_o` to 0.
  - The rest of the behaviour is identical.

## Test plan
- N=3, macro on: reqs arrive one per cycle with values 5, −2, 9; ready held high -> acks at +1 each; `class_o=2`, `max_o=9`; valid at T+3 for one cycle.
- N=3, all reqs in the same cycle with values 0x80000000, 0xFFFFFFFF, 0xFFFFFFFF -> all three acks in one cycle; `class_o=1` (signed max, tie keeps lower index).
- Ready held low 10 cycles in PRESENT while `req_i[0]` is re-raised with a new value -> no ack, outputs stable; ready high -> handshake, `req_i[0]` captured the next cycle.
- `req_i[1]` held for 5 cycles after its slot is full -> exactly one `ack_o[1]` pulse, `data[1]` unchanged.
- Reset asserted in SCAN -> next cycle all outputs 0, `busy_o=0`; re-present 1, 2, 3 -> `class_o=2`.
- Macro off, N=2 -> valid at T+1, `class_o=0`, `max_o=0`, `result_data_o` equals the inputs.
